// File: rtl/restore_divider_param.sv
// Restoring shift/subtract divider producing one quotient bit per clock.
// Optional two's-complement mode divides magnitudes, then fixes up the result signs.
module restore_divider_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned      CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam logic [WIDTH-1:0] Min  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + One;
    endfunction

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             zero_q, zero_d;
    logic             rneg_q, rneg_d;
    logic             qneg_q, qneg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             eff_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             step_bit;

    assign eff_signed = SIGNED_EN && signed_mode;
    assign a_neg      = eff_signed & dividend[WIDTH-1];
    assign b_neg      = eff_signed & divisor[WIDTH-1];
    assign a_mag      = a_neg ? negate(dividend) : dividend;
    assign b_mag      = b_neg ? negate(divisor) : divisor;

    // A borrow out of the extended subtraction means the trial subtract must be undone.
    assign diff     = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvsr_q};
    assign step_bit = ~diff[WIDTH+1];
    assign step_rem = step_bit ? diff[WIDTH:0] : {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign step_quo = {quo_q[WIDTH-2:0], step_bit};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        zero_d     = zero_q;
        rneg_d     = rneg_q;
        qneg_d     = qneg_q;
        ovf_pend_d = ovf_pend_q;
        res_quo_d  = res_quo_q;
        res_rem_d  = res_rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero divisor spends a single cycle in RUN to meet its one-edge latency.
                    zero_d     = (divisor == '0);
                    cnt_d      = (divisor == '0) ? CntW'(1) : CntW'(WIDTH);
                    rem_d      = '0;
                    quo_d      = (divisor == '0) ? dividend : a_mag;
                    dvsr_d     = b_mag;
                    rneg_d     = a_neg;
                    qneg_d     = a_neg ^ b_neg;
                    ovf_pend_d = eff_signed && (dividend == Min) && (divisor == '1);
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    if (zero_q) begin
                        res_quo_d = '1;
                        res_rem_d = quo_q;
                        dbz_d     = 1'b1;
                    end else begin
                        res_quo_d = qneg_q ? negate(step_quo) : step_quo;
                        res_rem_d = rneg_q ? negate(step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];
                        ovf_d     = ovf_pend_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            zero_q     <= 1'b0;
            rneg_q     <= 1'b0;
            qneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            zero_q     <= zero_d;
            rneg_q     <= rneg_d;
            qneg_q     <= qneg_d;
            ovf_pend_q <= ovf_pend_d;
            res_quo_q  <= res_quo_d;
            res_rem_q  <= res_rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = res_quo_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_restore_divider_param.sv
// Bench for restore_divider_param: three instances (signed 8-bit, unsigned-only 8-bit,
// signed 16-bit) checked every cycle against an arithmetic reference with timing model.
module tb_restore_divider_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic [2:0]  bsy, dn, dz, ov;
    logic [7:0]  q0, r0, q1, r1;
    logic [15:0] q2, r2;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    restore_divider_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u_s8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .dividend(a8), .divisor(b8),
        .busy(bsy[0]), .done(dn[0]), .quotient(q0), .remainder(r0),
        .div_by_zero(dz[0]), .overflow(ov[0])
    );

    restore_divider_param #(.WIDTH(8), .SIGNED_EN(1'b0)) u_u8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .dividend(a8), .divisor(b8),
        .busy(bsy[1]), .done(dn[1]), .quotient(q1), .remainder(r1),
        .div_by_zero(dz[1]), .overflow(ov[1])
    );

    restore_divider_param #(.WIDTH(16), .SIGNED_EN(1'b1)) u_s16 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .dividend(a16), .divisor(b16),
        .busy(bsy[2]), .done(dn[2]), .quotient(q2), .remainder(r2),
        .div_by_zero(dz[2]), .overflow(ov[2])
    );

    function automatic int w_of(input int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic bit sen_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [31:0] in_a(input int i);
        return (i == 2) ? 32'(a16) : 32'(a8);
    endfunction

    function automatic logic [31:0] in_b(input int i);
        return (i == 2) ? 32'(b16) : 32'(b8);
    endfunction

    function automatic logic [31:0] dq(input int i);
        return (i == 0) ? 32'(q0) : (i == 1) ? 32'(q1) : 32'(q2);
    endfunction

    function automatic logic [31:0] dr(input int i);
        return (i == 0) ? 32'(r0) : (i == 1) ? 32'(r1) : 32'(r2);
    endfunction

    // Reference: plain integer arithmetic; SV division truncates toward zero.
    function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input bit s, output logic [31:0] q, output logic [31:0] r,
                                    output bit zd, output bit of);
        longint mask = (longint'(1) << w) - 1;
        longint sa, sb;
        zd = 1'b0;
        of = 1'b0;
        if (b == 0) begin
            q  = 32'(mask);
            r  = a;
            zd = 1'b1;
        end else if (s) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            of = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
            q  = 32'((sa / sb) & mask);
            r  = 32'((sa % sb) & mask);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Timing model: an accepted op stays busy for latency+1 cycles, done in the last one.
    int          left[3];
    logic [31:0] eq[3], er[3], pq[3], pr[3];
    bit          edz[3], eov[3], pdz[3], pov[3];

    initial begin
        for (int i = 0; i < 3; i++) left[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                logic [31:0] tq, tr;
                bit td, to;
                if (rst) begin
                    left[i] = 0;
                    eq[i] = '0;
                    er[i] = '0;
                    edz[i] = 1'b0;
                    eov[i] = 1'b0;
                end else if (left[i] == 0) begin
                    if (start) begin
                        ref_div(w_of(i), in_a(i), in_b(i), sm && sen_of(i), tq, tr, td, to);
                        pq[i] = tq;
                        pr[i] = tr;
                        pdz[i] = td;
                        pov[i] = to;
                        left[i] = ((in_b(i) == 0) ? 1 : w_of(i)) + 1;
                        edz[i] = 1'b0;
                        eov[i] = 1'b0;
                    end
                end else begin
                    left[i] = left[i] - 1;
                    if (left[i] == 1) begin
                        eq[i] = pq[i];
                        er[i] = pr[i];
                        edz[i] = pdz[i];
                        eov[i] = pov[i];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(left[i] > 0));
                    chk($sformatf("done%0d", i), 32'(dn[i]), 32'(left[i] == 1));
                    chk($sformatf("quot%0d", i), dq(i), eq[i]);
                    chk($sformatf("rem%0d", i), dr(i), er[i]);
                    chk($sformatf("dbz%0d", i), 32'(dz[i]), 32'(edz[i]));
                    chk($sformatf("ovf%0d", i), 32'(ov[i]), 32'(eov[i]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((|bsy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", 32'(|bsy), 32'd0);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] aw,
                      input logic [15:0] bw, input bit s, input int idx, output int lat);
        @(negedge clk);
        a8 = a;
        b8 = b;
        a16 = aw;
        b16 = bw;
        sm = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!dn[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        wait_idle();
    endtask

    function automatic logic [31:0] rnd_op(input int w, input bit is_div);
        logic [31:0] mask = (32'd1 << w) - 1;
        case ($urandom_range(0, 15))
            0: return is_div ? 32'd0 : (32'd1 << (w - 1));
            1: return mask;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        int pulses[$];
        int cyc;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(bsy), 32'd0);
        chk("rst_quot0", 32'(q0), 32'd0);
        chk("rst_flags", 32'({dz, ov}), 32'd0);
        rst = 1'b0;

        op(8'd100, 8'd7, 16'd1, 16'hFFFF, 1'b0, 0, lat);
        chk("lat_100_7", 32'(lat), 32'd8);
        chk("q_100_7", 32'(q0), 32'd14);
        chk("r_100_7", 32'(r0), 32'd2);
        chk("flags_100_7", 32'({dz[0], ov[0]}), 32'd0);
        chk("q16_1_ffff", 32'(q2), 32'd0);
        chk("r16_1_ffff", 32'(r2), 32'd1);

        op(8'd5, 8'd0, 16'hFFFF, 16'd1, 1'b0, 2, lat);
        chk("lat16", 32'(lat), 32'd16);
        chk("q16_ffff_1", 32'(q2), 32'hFFFF);
        chk("r16_ffff_1", 32'(r2), 32'd0);

        op(8'd5, 8'd0, 16'd9, 16'd0, 1'b1, 0, lat);
        chk("lat_div0", 32'(lat), 32'd1);
        chk("q_div0", 32'(q0), 32'hFF);
        chk("r_div0", 32'(r0), 32'h05);
        chk("dbz_div0", 32'(dz[0]), 32'd1);

        op(8'h9C, 8'd7, 16'h8000, 16'hFFFF, 1'b1, 0, lat);
        chk("q_m100_7", 32'(q0), 32'hF2);
        chk("r_m100_7", 32'(r0), 32'hFE);
        chk("q_u156_7", 32'(q1), 32'd22);
        chk("ov16_min", 32'(ov[2]), 32'd1);

        op(8'd100, 8'hF9, 16'hFF9C, 16'd7, 1'b1, 0, lat);
        chk("q_100_m7", 32'(q0), 32'hF2);
        chk("r_100_m7", 32'(r0), 32'h02);
        chk("r16_m100_7", 32'(r2), 32'hFFFE);

        op(8'h80, 8'hFF, 16'd0, 16'd1, 1'b1, 0, lat);
        chk("lat_min_m1", 32'(lat), 32'd8);
        chk("q_min_m1", 32'(q0), 32'h80);
        chk("r_min_m1", 32'(r0), 32'd0);
        chk("ov_min_m1", 32'(ov[0]), 32'd1);
        chk("q_u128_255", 32'(q1), 32'd0);
        chk("r_u128_255", 32'(r1), 32'd128);
        chk("ov_u128_255", 32'(ov[1]), 32'd0);

        // Second start while busy must not disturb the first division.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd13; a16 = 16'd300; b16 = 16'd7; sm = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a8 = 8'd9; b8 = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle();
        chk("q_ign_start", 32'(q0), 32'd15);
        chk("r_ign_start", 32'(r0), 32'd5);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", 32'(bsy), 32'd0);
        chk("abort_quot", 32'({q0, r0}), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (|dn) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'd77; b8 = 8'd5; a16 = 16'd1000; b16 = 16'd3; sm = 1'b0; start = 1'b1;
        for (cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (dn[0]) pulses.push_back(cyc);
        end
        start = 1'b0;
        chk("b2b_count", 32'(pulses.size() >= 3), 32'd1);
        for (int i = 1; i < pulses.size(); i++)
            chk("b2b_period", 32'(pulses[i] - pulses[i-1]), 32'd10);
        wait_idle();

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            sm    = 1'($urandom);
            a8    = 8'(rnd_op(8, 1'b0));
            b8    = 8'(rnd_op(8, 1'b1));
            a16   = 16'(rnd_op(16, 1'b0));
            b16   = 16'(rnd_op(16, 1'b1));
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
